// File: rtl/player_ctrl.sv
// -----------------------------------------------------------------------------
// player_ctrl
//   Player position / lives controller for the LED dodging game.
//   Three raw buttons (BtnL, BtnR, Start) are synchronised, optionally
//   debounced, and turned into single-cycle pulses that drive a five-state
//   game FSM (IDLE, PLAY, HIT, WIN, OVER).
//
//   Build option:
//     PLAYER_DEBOUNCE_EN  defined   -> each synchronised button must hold a new
//                                      level for DEBOUNCE_CYCLES cycles before
//                                      it is accepted.
//                         undefined -> edge detection acts directly on the
//                                      synchronised buttons; DEBOUNCE_CYCLES
//                                      is not used.
// -----------------------------------------------------------------------------
module player_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HIT_CYCLES      = 25000000,
    parameter int LIVES_INIT      = 3
) (
    input  logic       Clk,
    input  logic       Clr,
    input  logic       BtnL,
    input  logic       BtnR,
    input  logic       Start,
    input  logic [6:0] obstacle,
    output logic [6:0] Player,
    output logic [1:0] Lives,
    output logic       Hit,
    output logic       Win,
    output logic       GameOver
);

    // Button lanes inside the packed button vectors.
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_S = 2;

    localparam int               HIT_W       = $clog2(HIT_CYCLES + 1);
    localparam logic [HIT_W-1:0] HIT_LAST    = HIT_W'(HIT_CYCLES - 1);
    localparam logic [1:0]       LIVES_START = 2'(LIVES_INIT);
    localparam logic [6:0]       POS_FIRST   = 7'b0000001;
    localparam logic [6:0]       POS_LAST    = 7'b1000000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAY,
        S_HIT,
        S_WIN,
        S_OVER
    } state_e;

    logic [2:0]       btn_raw;
    logic [2:0]       sync_q1;
    logic [2:0]       sync_q2;
    logic [2:0]       btn_level;
    logic [2:0]       btn_level_d;
    logic [2:0]       btn_pulse;
    logic             p_l;
    logic             p_r;
    logic             p_s;

    state_e           state_q;
    state_e           state_d;
    logic [6:0]       player_d;
    logic [1:0]       lives_d;
    logic [HIT_W-1:0] hit_cnt;
    logic             hit_done;

    assign btn_raw = {Start, BtnR, BtnL};

    // Two-flop synchroniser for all three asynchronous buttons.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            // NOTE: non-blocking assignments make sync_q2 take the old sync_q1,
            // giving two real flop stages; blocking would collapse them to one.
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

`ifdef PLAYER_DEBOUNCE_EN
    localparam int            DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0] db_cnt [3];

    // Debounce: accept a new level only after it has differed from the
    // accepted level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            btn_level <= '0;
            // NOTE: db_cnt is an array of ordinary flops, not a RAM, so every
            // entry is cleared by the async reset like any other state.
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync_q2[i] == btn_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    btn_level[i] <= sync_q2[i];
                    db_cnt[i]    <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end
`else
    assign btn_level = sync_q2;
`endif

    // Previous accepted level, used for rising-edge detection.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            btn_level_d <= '0;
        end else begin
            btn_level_d <= btn_level;
        end
    end

    assign btn_pulse = btn_level & ~btn_level_d;
    assign p_l       = btn_pulse[BTN_L];
    assign p_r       = btn_pulse[BTN_R];
    assign p_s       = btn_pulse[BTN_S];

    // Freeze timer: counts the cycles spent in HIT, cleared everywhere else.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            hit_cnt <= '0;
        end else if (state_q == S_HIT && !hit_done) begin
            hit_cnt <= hit_cnt + 1'b1;
        end else begin
            hit_cnt <= '0;
        end
    end

    assign hit_done = (state_q == S_HIT) && (hit_cnt == HIT_LAST);

    // State register plus registered outputs; flags decode the next state so
    // they change on the same edge as the state itself.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q  <= S_IDLE;
            Player   <= '0;
            Lives    <= '0;
            Hit      <= 1'b0;
            Win      <= 1'b0;
            GameOver <= 1'b0;
        end else begin
            state_q  <= state_d;
            Player   <= player_d;
            Lives    <= lives_d;
            Hit      <= (state_d == S_HIT);
            Win      <= (state_d == S_WIN);
            GameOver <= (state_d == S_OVER);
        end
    end

    // Next-state, next-position and next-lives logic.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        player_d = Player;
        lives_d  = Lives;

        unique case (state_q)
            S_IDLE, S_WIN, S_OVER: begin
                if (p_s) begin
                    state_d  = S_PLAY;
                    player_d = POS_FIRST;
                    lives_d  = LIVES_START;
                end
            end

            S_PLAY: begin
                // Collision beats the win check and discards any move pulse.
                if ((Player & obstacle) != '0) begin
                    state_d = S_HIT;
                    if (Lives != 2'd0) begin
                        lives_d = Lives - 2'd1;
                    end
                end else if (Player == POS_LAST) begin
                    state_d = S_WIN;
                end else if (p_r && !p_l) begin
                    player_d = Player << 1;
                end else if (p_l && !p_r && Player != POS_FIRST) begin
                    player_d = Player >> 1;
                end
            end

            S_HIT: begin
                if (hit_done) begin
                    if (Lives == 2'd0) begin
                        state_d  = S_OVER;
                        player_d = '0;
                    end else begin
                        state_d  = S_PLAY;
                        player_d = POS_FIRST;
                    end
                end
            end

            default: begin
                state_d  = S_IDLE;
                player_d = '0;
                lives_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_player_ctrl.sv
// -----------------------------------------------------------------------------
// tb_player_ctrl
//   Two player_ctrl instances (LIVES_INIT = 3 and 1) share one stimulus stream.
//   A game-rule model (position as an integer, lives as an integer, freeze as a
//   countdown, debounce as a run-length of the synchronised level) predicts the
//   outputs; they are compared on every falling edge. Directed steps with
//   literal expectations pin the model, followed by a randomised phase.
// -----------------------------------------------------------------------------
module tb_player_ctrl;

    localparam int N_DB = 16;
    localparam int H    = 20;
`ifdef PLAYER_DEBOUNCE_EN
    localparam int LAT  = N_DB + 3;
`else
    localparam int LAT  = 3;
`endif

    logic       Clk;
    logic       Clr;
    logic       BtnL;
    logic       BtnR;
    logic       Start;
    logic [6:0] obstacle;

    logic [6:0] player0, player1;
    logic [1:0] lives0, lives1;
    logic       hit0, hit1, win0, win1, over0, over1;

    player_ctrl #(.DEBOUNCE_CYCLES(N_DB), .HIT_CYCLES(H), .LIVES_INIT(3)) dut0 (
        .Clk(Clk), .Clr(Clr), .BtnL(BtnL), .BtnR(BtnR), .Start(Start),
        .obstacle(obstacle), .Player(player0), .Lives(lives0),
        .Hit(hit0), .Win(win0), .GameOver(over0)
    );

    player_ctrl #(.DEBOUNCE_CYCLES(N_DB), .HIT_CYCLES(H), .LIVES_INIT(1)) dut1 (
        .Clk(Clk), .Clr(Clr), .BtnL(BtnL), .BtnR(BtnR), .Start(Start),
        .obstacle(obstacle), .Player(player1), .Lives(lives1),
        .Hit(hit1), .Win(win1), .GameOver(over1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ------------------------------------------------------------ bookkeeping
    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ game model
    typedef enum {M_IDLE, M_PLAY, M_HIT, M_WIN, M_OVER} mstate_e;

    typedef struct {
        mstate_e st;
        int      pos;       // 0..6, index of the lit LED while playing
        int      lives;
        int      hit_left;  // cycles of freeze still to run
    } game_t;

    game_t    g [2];
    bit [2:0] h1, h2, h3;   // raw buttons sampled 1, 2, 3 edges ago
`ifdef PLAYER_DEBOUNCE_EN
    bit [2:0] lvl, lvl_prev, last_s;
    int       run [3];
`endif

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            g[k] = '{st: M_IDLE, pos: 0, lives: 0, hit_left: 0};
        end
        h1 = '0;
        h2 = '0;
        h3 = '0;
`ifdef PLAYER_DEBOUNCE_EN
        lvl      = '0;
        lvl_prev = '0;
        last_s   = '0;
        for (int i = 0; i < 3; i++) run[i] = 0;
`endif
    endtask

    task automatic game_step(input int k, input bit pl, input bit pr, input bit ps);
        case (g[k].st)
            M_IDLE, M_WIN, M_OVER: begin
                if (ps) begin
                    g[k].st    = M_PLAY;
                    g[k].pos   = 0;
                    g[k].lives = (k == 0) ? 3 : 1;
                end
            end
            M_PLAY: begin
                if (obstacle[g[k].pos]) begin
                    g[k].st       = M_HIT;
                    g[k].lives    = (g[k].lives > 0) ? g[k].lives - 1 : 0;
                    g[k].hit_left = H;
                end else if (g[k].pos == 6) begin
                    g[k].st = M_WIN;
                end else if (pr && !pl) begin
                    g[k].pos = g[k].pos + 1;
                end else if (pl && !pr && g[k].pos > 0) begin
                    g[k].pos = g[k].pos - 1;
                end
            end
            M_HIT: begin
                g[k].hit_left = g[k].hit_left - 1;
                if (g[k].hit_left == 0) begin
                    if (g[k].lives == 0) begin
                        g[k].st = M_OVER;
                    end else begin
                        g[k].st  = M_PLAY;
                        g[k].pos = 0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_step();
        bit [2:0] p;
`ifdef PLAYER_DEBOUNCE_EN
        bit [2:0] s;
        bit [2:0] nl;
        // A level is accepted once the synchronised value has stayed put for
        // N_DB samples in a row while differing from the accepted level.
        p  = lvl & ~lvl_prev;
        s  = h2;
        nl = lvl;
        for (int i = 0; i < 3; i++) begin
            if (s[i] == last_s[i]) begin
                if (run[i] < N_DB) run[i]++;
            end else begin
                run[i] = 1;
            end
            last_s[i] = s[i];
            if (s[i] != lvl[i] && run[i] >= N_DB) nl[i] = s[i];
        end
        lvl_prev = lvl;
        lvl      = nl;
`else
        p = h2 & ~h3;
`endif
        h3 = h2;
        h2 = h1;
        h1 = {Start, BtnR, BtnL};
        for (int k = 0; k < 2; k++) game_step(k, p[0], p[1], p[2]);
    endtask

    always @(posedge Clk or posedge Clr) begin
        if (Clr) model_reset();
        else     model_step();
    end

    function automatic logic [11:0] expect_out(input int k);
        logic [6:0] pl;
        case (g[k].st)
            M_IDLE, M_OVER: pl = 7'h00;
            M_WIN:          pl = 7'h40;
            default:        pl = 7'(1 << g[k].pos);
        endcase
        return {pl, 2'(g[k].lives), g[k].st == M_HIT, g[k].st == M_WIN, g[k].st == M_OVER};
    endfunction

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge Clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                logic [11:0] act;
                logic [11:0] exp_v;
                act   = (k == 0) ? {player0, lives0, hit0, win0, over0}
                                 : {player1, lives1, hit1, win1, over1};
                exp_v = expect_out(k);
                n_checks++;
                if (act !== exp_v) begin
                    n_fail++;
                    if (n_fail < 30)
                        $display("FAIL model_cmp dut%0d: got %03h, expected %03h (t=%0t)",
                                 k, act, exp_v, $time);
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #2;
        end
    endtask

    task automatic press(input bit l, input bit r, input bit s);
        BtnL  = l;
        BtnR  = r;
        Start = s;
        tick(LAT + 2);
        BtnL  = 1'b0;
        BtnR  = 1'b0;
        Start = 1'b0;
        tick(LAT + 3);
    endtask

    initial begin
        Clr      = 1'b0;
        BtnL     = 1'b0;
        BtnR     = 1'b0;
        Start    = 1'b0;
        obstacle = 7'h00;
        model_reset();
        #3 Clr = 1'b1;
        tick(2);

        // Reset state.
        check("reset_player",   player0, 7'h00);
        check("reset_lives",    lives0,  2'd0);
        check("reset_flags",    {hit0, win0, over0}, 3'b000);
        check_en = 1'b1;
        Clr = 1'b0;
        tick(2);

        // Start with a clean edge: PLAY exactly LAT edges after the raw edge.
        Start = 1'b1;
        tick(LAT - 1);
        check("start_not_yet",  player0, 7'h00);
        tick(1);
        check("start_player",   player0, 7'h01);
        check("start_lives",    lives0,  2'd3);
        check("start_lives1",   lives1,  2'd1);
        Start = 1'b0;
        tick(LAT + 3);

`ifdef PLAYER_DEBOUNCE_EN
        // Bouncing right button: short pulses rejected, one clean press moves.
        repeat (5) begin
            BtnR = 1'b1;
            tick(10);
            BtnR = 1'b0;
            tick(10);
        end
        check("bounce_ignored", player0, 7'h01);
        BtnR = 1'b1;
        tick(LAT + 2);
        BtnR = 1'b0;
        tick(LAT + 3);
        check("bounce_one_move", player0, 7'h02);
`else
        // Without the filter a right press lands three edges after the raw edge.
        BtnR = 1'b1;
        tick(LAT - 1);
        check("pr_not_yet",     player0, 7'h01);
        tick(1);
        check("pr_latency",     player0, 7'h02);
        BtnR = 1'b0;
        tick(LAT + 3);
`endif

        // Collision at position 1.
        obstacle = 7'b0000010;
        tick(1);
        check("hit_flag",       hit0,    1'b1);
        check("hit_lives",      lives0,  2'd2);
        check("hit_frozen",     player0, 7'h02);
        check("hit_lives1",     lives1,  2'd0);
        obstacle = 7'h00;
        tick(H - 1);
        check("hit_held",       hit0,    1'b1);
        tick(1);
        check("hit_end_flag",   hit0,    1'b0);
        check("hit_end_player", player0, 7'h01);
        check("over_flag1",     over1,   1'b1);
        check("over_player1",   player1, 7'h00);

        // Start restarts the finished game only.
        press(1'b0, 1'b0, 1'b1);
        check("restart_lives1",  lives1,  2'd1);
        check("restart_player1", player1, 7'h01);
        check("play_ignores_s",  lives0,  2'd2);

        // Six right moves reach the last LED and win.
        repeat (6) press(1'b0, 1'b1, 1'b0);
        check("win_player",     player0, 7'h40);
        check("win_flag",       win0,    1'b1);

        // Restart, then simultaneous left+right and left at the edge.
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        check("lr_same_cycle",  player0, 7'h02);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("left_at_edge",   player0, 7'h01);

        // Randomised play: button mixes, short/long holds, random obstacles.
        for (int it = 0; it < 60; it++) begin
            obstacle = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
            BtnL     = 1'($urandom_range(0, 1));
            BtnR     = 1'($urandom_range(0, 1));
            Start    = ($urandom_range(0, 3) == 0);
            tick($urandom_range(1, LAT + 4));
            BtnL  = 1'b0;
            BtnR  = 1'b0;
            Start = 1'b0;
            tick($urandom_range(1, LAT + 6));
        end
        obstacle = 7'h00;
        tick(H + 4);

        // Clear in the middle of a freeze drops everything without a clock edge.
        Clr = 1'b1;
        tick(1);
        Clr = 1'b0;
        tick(1);
        press(1'b0, 1'b0, 1'b1);
        obstacle = 7'h7f;
        tick(3);
        check("pre_clr_hit",    hit0,    1'b1);
        Clr = 1'b1;
        #1;
        check("clr_async_player", player0, 7'h00);
        check("clr_async_lives",  lives0,  2'd0);
        check("clr_async_hit",    {hit0, hit1}, 2'b00);
        check("clr_async_lives1", lives1,  2'd0);
        tick(2);
        Clr      = 1'b0;
        obstacle = 7'h00;
        tick(LAT + 5);
        check("idle_after_clr", player0, 7'h00);
        press(1'b0, 1'b0, 1'b1);
        check("start_after_clr", player0, 7'h01);
        tick(2);

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
